// File: rtl/tx_sched_16.sv
// -----------------------------------------------------------------------------
// tx_sched_16
// Doorbell-driven transmit scheduler front end for 16 send queues.
//
// This block keeps one saturating pending-work counter for each queue. Every
// non-zero counter raises its bit of rr_req towards an external 16-way
// round-robin arbiter. The block pulses rr_ena for one cycle and takes the
// registered one-hot grant one cycle later. It turns that grant into a queue
// number, presents the number to the TX pipeline over a valid/ready
// handshake, and retires one unit of work from the granted queue.
//
// Parameters
//   CNT_W        width of each pending counter (saturates at 2^CNT_W-1)
//
// Ports
//   sys_clk      clock, all logic on the rising edge
//   sys_rst_n    asynchronous active-low reset
//   db_valid     doorbell strobe, adds one work unit to queue db_qpn
//   db_qpn[3:0]  doorbell target queue
//   db_ovf       sticky, set when a doorbell hits a saturated counter
//   rr_req[15:0] request vector to the arbiter, bit i = (cnt[i] != 0)
//   rr_ena       one-cycle arbitration enable
//   rr_result    registered one-hot grant, valid the cycle after rr_ena
//   sched_valid  grant available to the TX pipeline
//   sched_qpn    granted queue number, stable while sched_valid is high
//   sched_ready  TX pipeline accepts the grant
//   sched_err    sticky illegal-grant flag
//
// Build option
//   TX_SCHED_GRANT_CHECK_EN  when defined, each grant is checked in WAIT.
//     A grant that is not exactly one-hot is illegal. A grant that names an
//     empty queue is also illegal. An illegal grant sets sched_err, retires
//     nothing, and returns the FSM to IDLE.
//     When not defined, sched_err is tied to 0. The lowest set bit of any
//     non-zero grant is used. An all-zero grant returns the FSM to IDLE
//     with no retire.
// -----------------------------------------------------------------------------
module tx_sched_16 #(
   parameter int CNT_W = 8
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        db_valid,
   input  logic [3:0]  db_qpn,
   output logic        db_ovf,
   output logic [15:0] rr_req,
   output logic        rr_ena,
   input  logic [15:0] rr_result,
   output logic        sched_valid,
   output logic [3:0]  sched_qpn,
   input  logic        sched_ready,
   output logic        sched_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARB,
      ST_WAIT,
      ST_OUT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t      state_reg;
   state_t      state_next;
   logic [3:0]  qpn_reg;
   logic [3:0]  qpn_next;
   logic        ovf_reg;
   logic [15:0] req_next;
   logic [15:0] ovf_hit;
   logic [3:0]  grant_qpn;
   logic        grant_ok;
   logic        retire_en;

   // Priority encoder: scan downwards so that the lowest set bit is kept.
   always_comb begin
      grant_qpn = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (rr_result[i]) begin
            grant_qpn = 4'(i);
         end
      end
   end

`ifdef TX_SCHED_GRANT_CHECK_EN
   logic grant_onehot;
   logic err_reg;

   assign grant_onehot = (rr_result != 16'd0) &&
                         ((rr_result & (rr_result - 16'd1)) == 16'd0);
   // A grant is legal only if it names a queue that still has work pending.
   assign grant_ok     = grant_onehot && rr_req[grant_qpn];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         err_reg <= 1'b0;
      end else if ((state_reg == ST_WAIT) && !grant_ok) begin
         err_reg <= 1'b1;
      end
   end

   assign sched_err = err_reg;
`else
   assign grant_ok  = (rr_result != 16'd0);
   assign sched_err = 1'b0;
`endif

   assign retire_en = (state_reg == ST_WAIT) && grant_ok;

   // One counter slice per queue.
   for (genvar gi = 0; gi < 16; gi++) begin : g_queue
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             inc;
      logic             dec;
      logic             sat;

      assign inc = db_valid && (db_qpn == 4'(gi));
      // The non-zero guard stops an unchecked grant to an empty queue from
      // wrapping the counter.
      assign dec = retire_en && (grant_qpn == 4'(gi)) && (cnt_reg != '0);
      assign sat = &cnt_reg;

      // A doorbell and a retire in the same cycle cancel out, even when
      // the counter is saturated.
      always_comb begin
         cnt_next = cnt_reg;
         if (inc && !dec) begin
            if (!sat) begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end else if (dec && !inc) begin
            cnt_next = cnt_reg - CNT_ONE;
         end
      end

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_next;
         end
      end

      assign ovf_hit[gi]  = inc && !dec && sat;
      assign rr_req[gi]   = (cnt_reg != '0);
      assign req_next[gi] = (cnt_next != '0);
   end

   // IDLE and OUT look at the post-update counters (req_next). A doorbell
   // seen in IDLE therefore reaches ARB in the very next cycle.
   always_comb begin
      state_next = state_reg;
      qpn_next   = qpn_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req_next != 16'd0) begin
               state_next = ST_ARB;
            end
         end
         ST_ARB: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (grant_ok) begin
               qpn_next   = grant_qpn;
               state_next = ST_OUT;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_OUT: begin
            if (sched_ready) begin
               state_next = (req_next != 16'd0) ? ST_ARB : ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg <= ST_IDLE;
         qpn_reg   <= 4'd0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         qpn_reg   <= qpn_next;
         ovf_reg   <= ovf_reg | (|ovf_hit);
      end
   end

   assign rr_ena      = (state_reg == ST_ARB);
   assign sched_valid = (state_reg == ST_OUT);
   assign sched_qpn   = qpn_reg;
   assign db_ovf      = ovf_reg;

endmodule
